// File: rtl/beam_select.sv
// Beam selector: each accepted RE beat is reduced from COL beams to NSEL beams.
// The beam index sets are prefetched from an external table into a pending/active pair of registers.

module beam_select_lane #(
    parameter int IW  = 32,
    parameter int COL = 64
) (
    input  logic [COL*IW-1:0] i_data,
    input  logic [7:0]        i_idx,
    output logic [IW-1:0]     o_beam,
    output logic              o_bad
);
    always_comb begin
        o_beam = '0;
        o_bad  = (32'(i_idx) >= COL);
        for (int c = 0; c < COL; c++)
            if (i_idx == 8'(c)) o_beam = i_data[c*IW +: IW];
    end
endmodule

module beam_select #(
    parameter int IW     = 32,
    parameter int COL    = 64,
    parameter int NSEL   = 16,
    parameter int RD_LAT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sort_done,
    input  logic [7:0]           i_rbg_max,
    output logic                 o_bid_rden,
    input  logic [NSEL*8-1:0]    i_beam_index,
    input  logic [COL*IW-1:0]    i_data,
    input  logic                 i_dvalid,
    input  logic                 i_rbg_last,
    output logic                 o_tready,
    output logic [NSEL*IW-1:0]   o_data,
    output logic                 o_tvalid,
    output logic                 o_tlast,
    output logic [7:0]           o_rbg_num,
    output logic                 o_err_idx
);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                state;
    logic [CW-1:0]         lat_cnt;
    logic [NSEL*8-1:0]     pnd_idx, act_idx;
    logic                  pnd_v, act_v;
    logic [7:0]            rbg_cnt;
    logic [NSEL*IW-1:0]    sel;
    logic [NSEL-1:0]       bad;

    logic accept, end_rbg, capture;
    assign accept   = i_dvalid & act_v;
    assign end_rbg  = accept & i_rbg_last;
    assign capture  = (state == WAIT) && (lat_cnt == CW'(RD_LAT - 1));
    assign o_tready = act_v;

    // Fetch: only one table read in flight, and only while pending is empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            o_bid_rden <= 1'b0;
        end else begin
            o_bid_rden <= 1'b0;
            case (state)
                IDLE:  if (i_sort_done && !pnd_v) begin
                           state      <= ISSUE;
                           o_bid_rden <= 1'b1;
                       end
                ISSUE: begin
                           state   <= WAIT;
                           lat_cnt <= '0;
                       end
                WAIT:  if (capture) state <= HOLD;
                       else         lat_cnt <= lat_cnt + CW'(1);
                HOLD:  if (!pnd_v) begin
                           if (i_sort_done) begin
                               state      <= ISSUE;
                               o_bid_rden <= 1'b1;
                           end else begin
                               state <= IDLE;
                           end
                       end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending fills only when empty, so capture and promotion never collide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pnd_v   <= 1'b0;
            act_v   <= 1'b0;
            pnd_idx <= '0;
            act_idx <= '0;
        end else begin
            if (capture) begin
                pnd_idx <= i_beam_index;
                pnd_v   <= 1'b1;
            end
            if (pnd_v && (!act_v || end_rbg)) begin
                act_idx <= pnd_idx;
                act_v   <= 1'b1;
                pnd_v   <= 1'b0;
            end else if (end_rbg) begin
                act_v <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NSEL; k++) begin : g_lane
        beam_select_lane #(.IW(IW), .COL(COL)) u_lane (
            .i_data (i_data),
            .i_idx  (act_idx[k*8 +: 8]),
            .o_beam (sel[k*IW +: IW]),
            .o_bad  (bad[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data    <= '0;
            o_tvalid  <= 1'b0;
            o_tlast   <= 1'b0;
            o_rbg_num <= '0;
            o_err_idx <= 1'b0;
            rbg_cnt   <= '0;
        end else begin
            o_tvalid <= accept;
            o_tlast  <= accept & i_rbg_last;
            if (accept) begin
                o_data    <= sel;
                o_rbg_num <= rbg_cnt;
                if (|bad) o_err_idx <= 1'b1;
            end
            if (end_rbg) rbg_cnt <= (rbg_cnt >= i_rbg_max) ? 8'd0 : rbg_cnt + 8'd1;
        end
    end
endmodule

// File: doc/beam_select.md
BEAM_SELECT -- requirements
Module: beam_select

Interface
REQ-001 Parameter IW, default 32: width of one beam sample.
REQ-002 Parameter COL, default 64: beams per input beat.
REQ-003 Parameter NSEL, default 16: beams selected per RBG.
REQ-004 Parameter RD_LAT, default 4: cycles from o_bid_rden to valid i_beam_index.
REQ-005 i_clk  in  1  clock; all logic on its rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_sort_done  in  1  level; beam index table holds at least one sorted RBG.
REQ-008 i_rbg_max  in  8  last RBG number before wrap to 0.
REQ-009 o_bid_rden  out  1  single-cycle read strobe to the index table; each pulse advances the table read address by one.
REQ-010 i_beam_index  in  NSEL x 8  index set; sampled exactly RD_LAT cycles after o_bid_rden.
REQ-011 i_data  in  COL x IW  one RE for all beams.
REQ-012 i_dvalid  in  1  i_data valid.
REQ-013 i_rbg_last  in  1  qualifies i_dvalid; last beat of current RBG.
REQ-014 o_tready  out  1  beat accepted when i_dvalid & o_tready.
REQ-015 o_data  out  NSEL x IW  selected beams; slot k = i_data[active_idx[k]].
REQ-016 o_tvalid, o_tlast  out  1 each  output beat valid / last beat of RBG.
REQ-017 o_rbg_num  out  8  RBG number of the output beat.
REQ-018 o_err_idx  out  1  sticky; an index >= COL was used.

Function
REQ-019 Index storage SHALL be two registers, pending and active, each NSEL x 8 plus a valid flag.
REQ-020 Fetch FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-021 IDLE -> ISSUE when i_sort_done=1 and pending empty.
REQ-022 ISSUE: o_bid_rden=1 for exactly one cycle; go to WAIT with latency counter cleared.
REQ-023 WAIT: count RD_LAT cycles; on the cycle i_beam_index is valid, capture into pending, set pending valid, go to HOLD.
REQ-024 HOLD -> ISSUE when pending becomes empty and i_sort_done=1; -> IDLE when pending empty and i_sort_done=0.
REQ-025 Not more than one read outstanding; o_bid_rden never asserted outside ISSUE.
REQ-026 Promotion: when active empty and pending valid, active <= pending, pending cleared, same cycle.
REQ-027 o_tready = active valid (combinational from register).
REQ-028 Accepted beat with i_rbg_last=1: if pending valid, active <= pending in the same cycle (no bubble); else active cleared.
REQ-029 Accepted beat: o_data, o_tvalid=1, o_tlast=i_rbg_last, o_rbg_num registered next cycle (latency 1); o_tvalid=0 on any non-accepting cycle.
REQ-030 Slot with index >= COL SHALL output zero and set o_err_idx; clears only on reset.
REQ-031 Local RBG counter: increments on each accepted i_rbg_last beat; wraps to 0 after i_rbg_max; i_rbg_max=0 keeps it at 0.
REQ-032 i_dvalid while o_tready=0 SHALL be ignored (no output, no state change); upstream holds data.
REQ-033 i_rbg_last without i_dvalid SHALL be ignored.

Reset
REQ-034 On i_reset: FSM IDLE, both sets invalid, latency and RBG counters 0, o_bid_rden=0, o_tready=0, o_tvalid=0, o_tlast=0, o_data=0, o_rbg_num=0, o_err_idx=0.
REQ-035 Reset mid-fetch SHALL discard the in-flight read; no capture occurs RD_LAT cycles later.
REQ-036 After reset release, first o_bid_rden no earlier than one cycle after i_sort_done is seen high.

Verification
REQ-037 Table RBG0 = {63,62,...,48}, i_sort_done=1, RD_LAT=4 -> one o_bid_rden; o_tready high 6 cycles later; beat i_data[b]=b -> o_data slot k = 63-k, latency 1.
REQ-038 Two RBGs of 3 beats each, back-to-back i_dvalid -> 6 o_tvalid with no gap; o_tlast on beats 3 and 6; o_rbg_num 0,0,0,1,1,1; exactly 3 o_bid_rden (prefetch).
REQ-039 i_rbg_max=2, stream 5 RBGs -> o_rbg_num sequence 0,1,2,0,1.
REQ-040 Index set containing 64 in slot 5 -> o_data[5]=0, o_err_idx=1 and stays 1 through later valid sets.
REQ-041 i_reset for 1 cycle two cycles after o_bid_rden -> no capture, o_tready stays 0 until a new fetch completes; all outputs 0 during reset.
REQ-042 i_sort_done=0 throughout with i_dvalid=1 -> o_bid_rden never asserted, o_tready=0, o_tvalid=0.
